// File: rtl/iig_pkg.sv
// Shared types and sizing helpers for the integral-image (iig) blocks.
package iig_pkg;

  localparam int unsigned DEF_DATA_W = 21;
  localparam int unsigned DEF_PIX_W  = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter width for a range of n values; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iig_line_buf.sv
// One-line store of integral values: simple dual-port RAM, 1-cycle read latency.
module iig_line_buf
  import iig_pkg::*;
#(
  parameter int unsigned DEPTH  = 320,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned AW     = cnt_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Array intentionally unreset; row 0 never consumes its contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/iig_stream_accum.sv
// Raster pixel stream to integral image: running row sum plus line-buffered column above.
module iig_stream_accum
  import iig_pkg::*;
#(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned PIX_W  = DEF_PIX_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned SQ_EN  = 0
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iSof,
  input  logic              iValid,
  input  logic [PIX_W-1:0]  iPixel,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oEol,
  output logic              oEof,
  output logic              oDrop,
  output logic              oBusy
);

  localparam int unsigned CW_W   = cnt_w(IMG_W);
  localparam int unsigned RW_W   = cnt_w(IMG_H);
  localparam int unsigned PROD_W = 2 * PIX_W;

  localparam logic [CW_W-1:0] COL_LAST = CW_W'(IMG_W - 1);
  localparam logic [RW_W-1:0] ROW_LAST = RW_W'(IMG_H - 1);

  state_e            state_q, state_d;
  logic [CW_W-1:0]   col_q, col_d;
  logic [RW_W-1:0]   row_q, row_d;

  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_p_q, s1_p_d;
  logic [CW_W-1:0]   s1_col_q, s1_col_d;
  logic              s1_col0_q, s1_col0_d;
  logic              s1_row0_q, s1_row0_d;
  logic              s1_eol_q, s1_eol_d;
  logic              s1_eof_q, s1_eof_d;

  logic [DATA_W-1:0] rs_q, rs_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic              drop_q, drop_d;
  logic              busy_q, busy_d;

  logic              start_c;
  logic              accept_c;
  logic [CW_W-1:0]   col_in_c;
  logic [RW_W-1:0]   row_in_c;
  logic              eol_in_c;
  logic              eof_in_c;
  logic [PROD_W-1:0] prod_c;
  logic [DATA_W-1:0] term_c;
  logic [DATA_W-1:0] rs_sum_c;
  logic [DATA_W-1:0] ii_c;
  logic [DATA_W-1:0] lb_rd_data;

  // Input qualification: a SOF pixel always restarts at (0,0).
  always_comb begin
    start_c  = iValid & iSof;
    accept_c = iValid & (iSof | (state_q == RUN));
    col_in_c = start_c ? '0 : col_q;
    row_in_c = start_c ? '0 : row_q;
    eol_in_c = (col_in_c == COL_LAST);
    eof_in_c = eol_in_c & (row_in_c == ROW_LAST);
    if (SQ_EN != 0) begin
      prod_c = PROD_W'(iPixel) * PROD_W'(iPixel);
    end else begin
      prod_c = PROD_W'(iPixel);
    end
    term_c = DATA_W'(prod_c);
  end

  // Second stage: row sum restarts at column 0, buffer term ignored on row 0.
  always_comb begin
    rs_sum_c = (s1_col0_q ? '0 : rs_q) + s1_p_q;
    ii_c     = rs_sum_c + (s1_row0_q ? '0 : lb_rd_data);
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    s1_vld_d  = 1'b0;
    s1_p_d    = s1_p_q;
    s1_col_d  = s1_col_q;
    s1_col0_d = s1_col0_q;
    s1_row0_d = s1_row0_q;
    s1_eol_d  = 1'b0;
    s1_eof_d  = 1'b0;
    rs_d      = rs_q;
    valid_d   = s1_vld_q;
    data_d    = data_q;
    eol_d     = 1'b0;
    eof_d     = 1'b0;
    drop_d    = iValid & ~iSof & (state_q == IDLE);

    if (accept_c) begin
      s1_vld_d  = 1'b1;
      s1_p_d    = term_c;
      s1_col_d  = col_in_c;
      s1_col0_d = (col_in_c == '0);
      s1_row0_d = (row_in_c == '0);
      s1_eol_d  = eol_in_c;
      s1_eof_d  = eof_in_c;
      state_d   = eof_in_c ? IDLE : RUN;
      if (eol_in_c) begin
        col_d = '0;
        row_d = eof_in_c ? '0 : row_in_c + RW_W'(1);
      end else begin
        col_d = col_in_c + CW_W'(1);
        row_d = row_in_c;
      end
    end

    if (s1_vld_q) begin
      rs_d   = rs_sum_c;
      data_d = ii_c;
      eol_d  = s1_eol_q;
      eof_d  = s1_eof_q;
    end

    busy_d = (state_d == RUN) | s1_vld_d | valid_d;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_p_q    <= '0;
      s1_col_q  <= '0;
      s1_col0_q <= 1'b0;
      s1_row0_q <= 1'b0;
      s1_eol_q  <= 1'b0;
      s1_eof_q  <= 1'b0;
      rs_q      <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      s1_vld_q  <= s1_vld_d;
      s1_p_q    <= s1_p_d;
      s1_col_q  <= s1_col_d;
      s1_col0_q <= s1_col0_d;
      s1_row0_q <= s1_row0_d;
      s1_eol_q  <= s1_eol_d;
      s1_eof_q  <= s1_eof_d;
      rs_q      <= rs_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end

  // Read for column c is issued with the pixel; write lands one cycle later.
  iig_line_buf #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .AW     (CW_W)
  ) u_line_buf (
    .clk_i     (iClk),
    .rd_en_i   (accept_c),
    .rd_addr_i (col_in_c),
    .rd_data_o (lb_rd_data),
    .wr_en_i   (s1_vld_q),
    .wr_addr_i (s1_col_q),
    .wr_data_i (ii_c)
  );

  assign oValid = valid_q;
  assign oData  = data_q;
  assign oEol   = eol_q;
  assign oEof   = eof_q;
  assign oDrop  = drop_q;
  assign oBusy  = busy_q;

endmodule

// File: tb/tb_iig_stream_accum.sv
// Scoreboard bench: three 4x3 configurations (plain, squared, 8-bit wrap) share one stimulus stream.
module tb_iig_stream_accum;

  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sof = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] pix = 8'd0;

  logic        v [3];
  logic        e [3];
  logic        f [3];
  logic        dr [3];
  logic        bz [3];
  logic [20:0] d0, d1;
  logic [7:0]  d2;

  typedef struct {
    longint data;
    bit     eol;
    bit     eof;
    int     cyc;
  } exp_t;

  exp_t   q0[$], q1[$], q2[$];
  longint pt [3][H][W];
  int     dwv [3] = '{21, 21, 8};
  int     sqv [3] = '{0, 1, 0};
  longint last_d [3] = '{0, 0, 0};
  int     got_drop [3] = '{0, 0, 0};
  int     exp_drop = 0;
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  bit     active = 0;
  int     col = 0;
  int     row = 0;

  iig_stream_accum #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .DATA_W(21), .SQ_EN(0)) dut0 (
    .iClk(clk), .iReset(rst), .iSof(sof), .iValid(vld), .iPixel(pix),
    .oValid(v[0]), .oData(d0), .oEol(e[0]), .oEof(f[0]), .oDrop(dr[0]), .oBusy(bz[0]));
  iig_stream_accum #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .DATA_W(21), .SQ_EN(1)) dut1 (
    .iClk(clk), .iReset(rst), .iSof(sof), .iValid(vld), .iPixel(pix),
    .oValid(v[1]), .oData(d1), .oEol(e[1]), .oEof(f[1]), .oDrop(dr[1]), .oBusy(bz[1]));
  iig_stream_accum #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .DATA_W(8), .SQ_EN(0)) dut2 (
    .iClk(clk), .iReset(rst), .iSof(sof), .iValid(vld), .iPixel(pix),
    .oValid(v[2]), .oData(d2), .oEol(e[2]), .oEof(f[2]), .oDrop(dr[2]), .oBusy(bz[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint dout(int k);
    case (k)
      0: return longint'(d0);
      1: return longint'(d1);
      default: return longint'(d2);
    endcase
  endfunction

  task automatic chk(string name, int k, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  task automatic push(int k, exp_t x);
    case (k)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic check_out(int k);
    exp_t x;
    bit   have;
    have = 0;
    if (!v[k]) begin
      chk("idle_flags", k, longint'({e[k], f[k]}), 0);
      chk("data_hold", k, dout(k), last_d[k]);
      return;
    end
    case (k)
      0: if (q0.size() > 0) begin x = q0.pop_front(); have = 1; end
      1: if (q1.size() > 0) begin x = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0) begin x = q2.pop_front(); have = 1; end
    endcase
    last_d[k] = dout(k);
    if (!have) begin
      chk("unexpected_output", k, 1, 0);
      return;
    end
    chk("data", k, dout(k), x.data);
    chk("eol", k, longint'(e[k]), longint'(x.eol));
    chk("eof", k, longint'(f[k]), longint'(x.eof));
    chk("latency_cycle", k, cyc, x.cyc);
  endtask

  // Monitor: checks every presented output against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        check_out(k);
        if (dr[k]) got_drop[k]++;
      end
    end
  end

  // Reference: II(x,y) is the plain sum of all terms above-left, modulo 2^DATA_W.
  task automatic send(bit s, logic [7:0] p);
    exp_t   x;
    longint sum;
    longint mask;
    @(negedge clk);
    sof = s;
    vld = 1'b1;
    pix = p;
    if (s || active) begin
      if (s) begin
        col = 0;
        row = 0;
        active = 1;
      end
      for (int k = 0; k < 3; k++) begin
        pt[k][row][col] = (sqv[k] != 0) ? longint'(p) * longint'(p) : longint'(p);
        sum = 0;
        for (int rr = 0; rr <= row; rr++)
          for (int cc = 0; cc <= col; cc++)
            sum += pt[k][rr][cc];
        mask = (longint'(1) << dwv[k]) - 1;
        x.data = sum & mask;
        x.eol = (col == W - 1);
        x.eof = (col == W - 1) && (row == H - 1);
        x.cyc = cyc + 2;
        push(k, x);
      end
      if (col == W - 1) begin
        col = 0;
        if (row == H - 1) begin
          row = 0;
          active = 0;
        end else begin
          row++;
        end
      end else begin
        col++;
      end
    end else begin
      exp_drop++;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      vld = 1'b0;
      sof = 1'b0;
    end
  endtask

  task automatic check_all_zero(string name);
    for (int k = 0; k < 3; k++) begin
      chk({name, "_valid"}, k, longint'(v[k]), 0);
      chk({name, "_data"}, k, dout(k), 0);
      chk({name, "_flags"}, k, longint'({e[k], f[k], dr[k]}), 0);
      chk({name, "_busy"}, k, longint'(bz[k]), 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    vld = 1'b0;
    sof = 1'b0;
    #1;
    check_all_zero("reset");
    q0.delete();
    q1.delete();
    q2.delete();
    for (int k = 0; k < 3; k++) last_d[k] = 0;
    active = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic rand_frame(int bub_pct, int rs_pct);
    send(1'b1, 8'($urandom));
    for (int i = 1; i < W * H; i++) begin
      if ($urandom_range(99) < bub_pct) idle(int'($urandom_range(1, 2)));
      send($urandom_range(99) < rs_pct, 8'($urandom));
    end
  endtask

  initial begin
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("por");
    @(negedge clk);
    #2;
    rst = 1'b0;
    idle(2);

    // All ones, back-to-back.
    send(1'b1, 8'd1);
    send(1'b0, 8'd1);
    send(1'b0, 8'd1);
    for (int k = 0; k < 3; k++) chk("busy_mid", k, longint'(bz[k]), 1);
    repeat (9) send(1'b0, 8'd1);
    idle(4);
    for (int k = 0; k < 3; k++) chk("busy_after", k, longint'(bz[k]), 0);

    // Pixel 3 with single-cycle bubbles.
    send(1'b1, 8'd3);
    repeat (11) begin
      idle(1);
      send(1'b0, 8'd3);
    end
    idle(3);

    // 255 everywhere exercises 8-bit wrap.
    send(1'b1, 8'd255);
    repeat (11) send(1'b0, 8'd255);
    idle(3);

    // Stray pixel with no frame active.
    send(1'b0, 8'd7);
    idle(1);
    for (int k = 0; k < 3; k++) chk("drop_pulse", k, longint'(dr[k]), 1);
    idle(1);
    for (int k = 0; k < 3; k++) chk("drop_one_cycle", k, longint'(dr[k]), 0);

    // Restart at row1 col2, then a full frame of 2s.
    send(1'b1, 8'd1);
    repeat (5) send(1'b0, 8'd1);
    send(1'b1, 8'd2);
    repeat (11) send(1'b0, 8'd2);
    idle(3);

    // Reset mid-row1, then a clean frame.
    send(1'b1, 8'd5);
    repeat (5) send(1'b0, 8'd9);
    do_reset();
    send(1'b1, 8'd4);
    repeat (11) send(1'b0, 8'd6);
    idle(3);

    // Randomized frames with bubbles, restarts and strays.
    for (int fr = 0; fr < 12; fr++) begin
      rand_frame(int'($urandom_range(0, 50)), (fr % 3 == 2) ? 8 : 0);
      if ($urandom_range(1) == 1) send(1'b0, 8'($urandom));
      idle(int'($urandom_range(0, 3)));
    end
    idle(6);

    chk("drain_q0", 0, q0.size(), 0);
    chk("drain_q1", 1, q1.size(), 0);
    chk("drain_q2", 2, q2.size(), 0);
    for (int k = 0; k < 3; k++) chk("drop_count", k, got_drop[k], exp_drop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
